hazard_issue_controller: RTL and testbench



---
 rtl/hazard_issue_controller_if.sv | 33 +++
 rtl/hazard_issue_controller.sv | 68 ++++++
 tb/tb_hazard_issue_controller.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/hazard_issue_controller_if.sv
// hazard_issue_controller_if: decode, writeback and branch bundle; stall_cycles exists only with HAZ_PERF_EN
interface hazard_issue_controller_if #(
    parameter int NREG = 32,
    parameter int AW = 5
);
    logic            id_valid, id_rw, id_mb;
    logic [1:0]      id_bs;
    logic [AW-1:0]   id_da, id_aa, id_ba;
    logic            wb_valid;
    logic [AW-1:0]   wb_da;
    logic            br_done, br_taken;
    logic            issue, stall, flush;
    logic [3:0]      inflight_cnt;
    logic [NREG-1:0] busy_vec;
    logic            sb_error;
`ifdef HAZ_PERF_EN
    logic [15:0]     stall_cycles;
`endif
    modport master (
        output id_valid, id_rw, id_mb, id_bs, id_da, id_aa, id_ba, wb_valid, wb_da, br_done, br_taken,
        input  issue, stall, flush, inflight_cnt, busy_vec, sb_error
`ifdef HAZ_PERF_EN
        , input stall_cycles
`endif
    );
    modport slave (
        input  id_valid, id_rw, id_mb, id_bs, id_da, id_aa, id_ba, wb_valid, wb_da, br_done, br_taken,
        output issue, stall, flush, inflight_cnt, busy_vec, sb_error
`ifdef HAZ_PERF_EN
        , output stall_cycles
`endif
    );
endinterface

// File: rtl/hazard_issue_controller.sv
// hazard_issue_controller: register scoreboard, hazard stall, branch wait and flush sequencing; HAZ_PERF_EN adds stall_cycles
module hazard_issue_controller #(
    parameter int NREG = 32,
    parameter int AW = 5,
    parameter int MAX_INFLIGHT = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input logic clk,
    input logic reset,
    hazard_issue_controller_if.slave bus
);
    typedef enum logic [1:0] {RUN, BR_WAIT, FLUSH} state_t;
    state_t          state_q;
    logic [NREG-1:0] busy_q, busy_d, wb_mask, eff;
    logic [3:0]      cnt_q, cnt_d;
    logic [2:0]      fcnt_q;
    logic            err_q, wb_hit, hazard, issue, wr;
    always_comb begin
        wb_mask = NREG'(bus.wb_valid) << bus.wb_da;
        eff     = busy_q & ~wb_mask;
        wb_hit  = bus.wb_valid & busy_q[bus.wb_da];
        hazard  = eff[bus.id_aa] | (~bus.id_mb & eff[bus.id_ba]) | (bus.id_rw & eff[bus.id_da])
                | (bus.id_rw & (cnt_q == 4'(MAX_INFLIGHT)) & ~wb_hit);
        issue   = bus.id_valid & (state_q == RUN) & ~hazard & ~reset;
        wr      = issue & bus.id_rw;
        busy_d  = eff | (NREG'(wr) << bus.id_da);
        cnt_d   = cnt_q + 4'(wr) - 4'(wb_hit);
    end
    assign bus.issue        = issue;
    assign bus.stall        = reset | (bus.id_valid & ~issue) | (state_q != RUN);
    assign bus.flush        = ~reset & (state_q == FLUSH);
    assign bus.inflight_cnt = cnt_q;
    assign bus.busy_vec     = busy_q;
    assign bus.sb_error     = err_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            busy_q  <= '0;
            cnt_q   <= '0;
            fcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_q | (bus.wb_valid & ~busy_q[bus.wb_da]);
            case (state_q)
                RUN:     if (issue && bus.id_bs != 2'b00) state_q <= BR_WAIT;
                BR_WAIT: if (bus.br_done) begin
                    state_q <= bus.br_taken ? FLUSH : RUN;
                    fcnt_q  <= 3'(FLUSH_CYCLES);
                end
                FLUSH: begin
                    fcnt_q <= fcnt_q - 3'd1;
                    if (fcnt_q == 3'd1) state_q <= RUN;
                end
                default: state_q <= RUN;
            endcase
        end
    end
`ifdef HAZ_PERF_EN
    logic [15:0] stall_cycles_q;
    always_ff @(posedge clk) begin
        if (reset) stall_cycles_q <= '0;
        else if (bus.stall && stall_cycles_q != 16'hFFFF) stall_cycles_q <= stall_cycles_q + 16'd1;
    end
    assign bus.stall_cycles = stall_cycles_q;
`endif
endmodule

// File: tb/tb_hazard_issue_controller.sv
// tb_hazard_issue_controller: directed and random stimulus, reference model feeds a scoreboard queue checked by a monitor
module tb_hazard_issue_controller;
    localparam int MAXI = 4;
    localparam int FLC = 2;
    typedef struct {
        logic        iss, stl, fl, err;
        logic [31:0] busy;
        logic [3:0]  cnt;
        logic [15:0] perf;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    hazard_issue_controller_if bus();
    hazard_issue_controller #(.MAX_INFLIGHT(MAXI), .FLUSH_CYCLES(FLC)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    exp_t q[$];
    exp_t m;
    int total = 0, bad = 0;
    bit bz[32];
    int mode = 0, fl_left = 0, pc = 0;
    bit err = 1'b0;
    function automatic int nbusy();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(bz[i]);
        return n;
    endfunction
    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, req);
        end
    endfunction
    task automatic step(input bit r, v, rw, mb, input bit [1:0] bs, input int da, aa, ba,
                        input bit wv, input int wd, input bit bd, bt);
        exp_t e;
        bit eff[32];
        bit hz, full;
        @(posedge clk);
        #1;
        reset = r; bus.id_valid = v; bus.id_rw = rw; bus.id_mb = mb; bus.id_bs = bs;
        bus.id_da = 5'(da); bus.id_aa = 5'(aa); bus.id_ba = 5'(ba);
        bus.wb_valid = wv; bus.wb_da = 5'(wd); bus.br_done = bd; bus.br_taken = bt;
        eff = bz;
        if (wv) eff[wd] = 1'b0;
        full = nbusy() == MAXI;
        hz = eff[aa] || (!mb && eff[ba]) || (rw && eff[da]) || (rw && full && !(wv && bz[wd]));
        e.iss = !r && v && mode == 0 && !hz;
        e.stl = r || (v && !e.iss) || mode != 0;
        e.fl = !r && mode == 2;
        for (int i = 0; i < 32; i++) e.busy[i] = bz[i];
        e.cnt = 4'(nbusy());
        e.err = err;
        e.perf = 16'(pc);
        q.push_back(e);
        if (r) begin
            for (int i = 0; i < 32; i++) bz[i] = 1'b0;
            mode = 0; fl_left = 0; err = 1'b0; pc = 0;
        end else begin
            if (e.stl && pc < 65535) pc++;
            if (wv && !bz[wd]) err = 1'b1;
            if (wv) bz[wd] = 1'b0;
            if (e.iss && rw) bz[da] = 1'b1;
            if (mode == 0) begin
                if (e.iss && bs != 2'b00) mode = 1;
            end else if (mode == 1) begin
                if (bd) begin
                    mode = bt ? 2 : 0;
                    fl_left = FLC;
                end
            end else begin
                fl_left--;
                if (fl_left == 0) mode = 0;
            end
        end
    endtask
    task automatic idle(input bit wv = 1'b0, input int wd = 0);
        step(0, 0, 0, 0, 2'b00, 0, 0, 0, wv, wd, 0, 0);
    endtask
    initial forever begin
        @(negedge clk);
        if (q.size() > 0) begin
            m = q.pop_front();
            chk("issue", 32'(bus.issue), 32'(m.iss));
            chk("stall", 32'(bus.stall), 32'(m.stl));
            chk("flush", 32'(bus.flush), 32'(m.fl));
            chk("busy_vec", bus.busy_vec, m.busy);
            chk("inflight_cnt", 32'(bus.inflight_cnt), 32'(m.cnt));
            chk("sb_error", 32'(bus.sb_error), 32'(m.err));
`ifdef HAZ_PERF_EN
            chk("stall_cycles", 32'(bus.stall_cycles), 32'(m.perf));
`endif
        end
    end
    initial begin
        bus.id_valid = 0; bus.id_rw = 0; bus.id_mb = 0; bus.id_bs = 0;
        bus.id_da = 0; bus.id_aa = 0; bus.id_ba = 0;
        bus.wb_valid = 0; bus.wb_da = 0; bus.br_done = 0; bus.br_taken = 0;
        step(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 2'b00, 1, 0, 0, 1, 3, 1, 1);
        idle();
        step(0, 1, 1, 0, 2'b00, 3, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 2'b00, 4, 3, 5, 0, 0, 0, 0);
        step(0, 1, 1, 0, 2'b00, 4, 3, 5, 0, 0, 0, 0);
        step(0, 1, 1, 0, 2'b00, 4, 3, 5, 1, 3, 0, 0);
        idle(1, 4);
        step(0, 1, 1, 0, 2'b00, 7, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 2'b00, 8, 2, 7, 0, 0, 0, 0);
        idle(1, 7);
        idle(1, 8);
        for (int i = 1; i <= 4; i++) step(0, 1, 1, 1, 2'b00, i, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 2'b00, 5, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 2'b00, 5, 0, 0, 1, 1, 0, 0);
        for (int i = 2; i <= 5; i++) idle(1, i);
        step(0, 1, 0, 1, 2'b01, 0, 6, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 2'b00, 10, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 2'b00, 10, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 2'b00, 0, 1, 2, 0, 0, 0, 0);
        step(0, 1, 0, 1, 2'b10, 0, 6, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 2'b00, 0, 1, 2, 0, 0, 1, 0);
        step(0, 1, 0, 0, 2'b00, 0, 1, 2, 0, 0, 0, 0);
        step(0, 1, 1, 1, 2'b11, 9, 4, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 2'b00, 0, 1, 2, 0, 0, 1, 0);
        idle(1, 9);
        idle(1, 12);
        idle();
        step(0, 1, 1, 1, 2'b01, 13, 0, 0, 0, 0, 0, 0);
        idle();
        step(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        idle();
        idle(1, 13);
        for (int n = 0; n < 3000; n++) begin
            int bl[$];
            int wd;
            bit r;
            for (int i = 0; i < 32; i++) if (bz[i]) bl.push_back(i);
            wd = (bl.size() > 0 && $urandom_range(99) < 97) ? bl[$urandom_range(bl.size() - 1)] : int'($urandom_range(7));
            r = $urandom_range(199) == 0;
            step(r, $urandom_range(9) < 7, $urandom_range(9) < 7, $urandom_range(9) < 3,
                 ($urandom_range(9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                 $urandom_range(7), $urandom_range(7), $urandom_range(7),
                 $urandom_range(9) < 4, wd, $urandom_range(3) == 0, $urandom_range(1) == 1);
        end
        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
